// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types for the cpu/alu multicycle add/subtract datapath.
//   op_e        : operation select (ADD / SUB)
//   state_e     : sequencer states of multicycle_addsub (IDLE / RUN / DONE)
//   alu_flags_t : ALU flag bundle {c, v, z, n}
//   full_add    : the 1-bit full-adder cell, returns {carry_out, sum}
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic c;  // carry out of MSB (SUB: 1 = no borrow)
        logic v;  // signed overflow
        logic z;  // result is zero
        logic n;  // result MSB
    } alu_flags_t;

    function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
        return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
    endfunction

endpackage

// File: rtl/multicycle_addsub_ripple_slice.sv
// -----------------------------------------------------------------------------
// ripple_slice
// Combinational CHUNK-bit ripple-carry adder built from the 1-bit full_add cell.
// Ports:
//   a, b      in  CHUNK  slice operands
//   cin       in  1      carry into bit 0
//   sum       out CHUNK  slice sum
//   cout      out 1      carry out of bit CHUNK-1
//   c_msb_in  out 1      carry into bit CHUNK-1 (signed-overflow detection)
// -----------------------------------------------------------------------------
module ripple_slice
    import alu_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign {w_carry[i+1], sum[i]} = full_add(a[i], b[i], w_carry[i]);
    end

    assign cout     = w_carry[CHUNK];
    assign c_msb_in = w_carry[CHUNK-1];

endmodule

// File: rtl/multicycle_addsub.sv
// -----------------------------------------------------------------------------
// multicycle_addsub
// Sequential WIDTH-bit add/subtract that reuses one CHUNK-bit ripple slice,
// processing one slice per clock (LSB slice first).
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid is never conditioned on ready.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operation request handshake (ready only in IDLE)
//   a, b                WIDTH-bit operands
//   cin                 carry-in for ADD, borrow-in for SUB
//   op                  op_e: 0 = ADD, 1 = SUB
//   out_valid/out_ready result handshake (valid only in DONE)
//   sum                 WIDTH-bit result
//   flag_c/v/z/n        carry, signed overflow, zero, negative
// -----------------------------------------------------------------------------
module multicycle_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_n
);

    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_param_err
        $error("multicycle_addsub: WIDTH must be a multiple of CHUNK with 1 <= CHUNK <= WIDTH");
    end

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NCHUNK - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [CW-1:0]    r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;       // already inverted for SUB
    logic [WIDTH-1:0] r_acc;     // partial result being built slice by slice
    logic [WIDTH-1:0] r_sum;     // published result, only updated on the last slice
    logic             r_carry;
    logic             r_in_ready;
    alu_flags_t       r_flags;

    logic [31:0]      w_base;
    logic [CHUNK-1:0] w_a_slice;
    logic [CHUNK-1:0] w_b_slice;
    logic [CHUNK-1:0] w_slice_sum;
    logic             w_slice_cout;
    logic             w_slice_c_msb_in;
    logic [WIDTH-1:0] w_result;
    logic             w_last;
    logic             w_accept;

    assign w_base    = 32'(r_idx) * 32'(CHUNK);
    assign w_a_slice = r_a[w_base +: CHUNK];
    assign w_b_slice = r_b[w_base +: CHUNK];
    assign w_last    = (r_idx == LAST_IDX);
    assign w_accept  = (r_state == ST_IDLE) && r_in_ready && in_valid;

    ripple_slice #(.CHUNK(CHUNK)) u_slice (
        .a        (w_a_slice),
        .b        (w_b_slice),
        .cin      (r_carry),
        .sum      (w_slice_sum),
        .cout     (w_slice_cout),
        .c_msb_in (w_slice_c_msb_in)
    );

    // Accumulator with the current slice merged in; on the last slice this is
    // the complete result, so flags can be taken from it directly.
    always_comb begin
        w_result = r_acc;
        w_result[w_base +: CHUNK] = w_slice_sum;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last)    w_state_next = ST_DONE;
            ST_DONE: if (out_ready) w_state_next = ST_IDLE;
            default:                w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_flags    <= '0;
            r_in_ready <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Registered so in_ready stays low while reset is held and rises
            // on the first edge after release.
            r_in_ready <= (w_state_next == ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= (op == OP_SUB) ? ~b : b;
                        r_carry <= (op == OP_SUB) ? ~cin : cin;
                        r_idx   <= '0;
                        r_acc   <= '0;
                    end
                end
                ST_RUN: begin
                    r_acc   <= w_result;
                    r_carry <= w_slice_cout;
                    r_idx   <= w_last ? '0 : r_idx + 1'b1;
                    if (w_last) begin
                        r_sum     <= w_result;
                        r_flags.c <= w_slice_cout;
                        r_flags.v <= w_slice_cout ^ w_slice_c_msb_in;
                        r_flags.z <= (w_result == '0);
                        r_flags.n <= w_result[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state == ST_DONE);
    assign sum       = r_sum;
    assign flag_c    = r_flags.c;
    assign flag_v    = r_flags.v;
    assign flag_z    = r_flags.z;
    assign flag_n    = r_flags.n;

endmodule

// File: tb/tb_multicycle_addsub.sv
module tb_multicycle_addsub;

  localparam int MW = 16;
  localparam int MC = 4;
  localparam int MN = MW / MC;
  localparam int EW = MW + 4;

  typedef struct packed {
    logic [31:0] sum;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } res_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic op);
    res_t r;
    longint m, half, ua, ub, sa, sb, ci, ur, sr, res;
    m    = longint'(1) << w;
    half = m >> 1;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = (ua >= half) ? ua - m : ua;
    sb   = (ub >= half) ? ub - m : ub;
    ci   = cin ? 1 : 0;
    if (!op) begin
      ur  = ua + ub + ci;
      sr  = sa + sb + ci;
      r.c = (ur >= m);
    end else begin
      ur  = ua - ub - ci;
      sr  = sa - sb - ci;
      r.c = (ur >= 0);
    end
    r.v   = (sr >= half) || (sr < -half);
    res   = ur & (m - 1);
    r.sum = 32'(res);
    r.z   = (res == 0);
    r.n   = (res >= half);
    return r;
  endfunction

  function automatic logic [EW-1:0] exp16(input res_t r);
    return {r.sum[MW-1:0], r.c, r.v, r.z, r.n};
  endfunction

  // ---------------- main DUT (16/4) ----------------
  logic          in_valid, in_ready, cin, op, out_valid, out_ready;
  logic [MW-1:0] a, b, sum;
  logic          flag_c, flag_v, flag_z, flag_n;

  multicycle_addsub #(.WIDTH(MW), .CHUNK(MC)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .flag_z    (flag_z),
    .flag_n    (flag_n)
  );

  logic [EW-1:0] dut_res;
  assign dut_res = {sum, flag_c, flag_v, flag_z, flag_n};

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_res = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      last_res = '0;
    end else if (out_valid) begin
      check("exp_available", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        check("result", dut_res, exp_q[0]);
        if (out_ready) last_res = exp_q.pop_front();
      end
    end else begin
      check("hold_previous", dut_res, last_res);
    end
  end

  // ---------------- driver ----------------
  task automatic drive_op(input string name, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tcin, input logic top, input int hold, input bit early,
                          input bit has_lit, input logic [EW-1:0] lit);
    int t;
    int lat;
    logic [EW-1:0] e;
    e = exp16(model(MW, 32'(ta), 32'(tb), tcin, top));
    if (has_lit) check({"model_", name}, e, lit);
    t = 0;
    @(posedge clk); #1;
    while (!in_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check({name, "_in_ready_idle"}, in_ready, 1);
    a = ta; b = tb; cin = tcin; op = top; in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    // Accepted; keep in_valid high with different operands, which must be ignored.
    a = ~ta; b = ~tb; cin = ~tcin; op = ~top;
    out_ready = early;
    lat = 1;
    while (!out_valid && lat < 20) begin
      check({name, "_in_ready_run"}, in_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check({name, "_latency"}, lat, MN + 1);
    if (has_lit) check(name, dut_res, lit);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      a = $urandom_range(0, 16'hFFFF);
      @(posedge clk); #1;
      check({name, "_bp_in_ready"}, in_ready, 0);
      check({name, "_bp_out_valid"}, out_valid, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_valid_drop"}, out_valid, 0);
    check({name, "_ready_back"}, in_ready, 1);
  endtask

  // ---------------- parameter sweep instances ----------------
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int SW = (g == 2) ? 32 : 16;
    localparam int SC = (g == 0) ? 1 : ((g == 1) ? 16 : 8);
    localparam int SN = SW / SC;

    logic          s_rst_n, s_in_valid, s_in_ready, s_cin, s_op, s_out_valid, s_out_ready;
    logic [SW-1:0] s_a, s_b, s_sum;
    logic          s_fc, s_fv, s_fz, s_fn;
    logic          done_flag;

    multicycle_addsub #(.WIDTH(SW), .CHUNK(SC)) u_dut (
      .clk       (clk),
      .rst_n     (s_rst_n),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .a         (s_a),
      .b         (s_b),
      .cin       (s_cin),
      .op        (s_op),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .sum       (s_sum),
      .flag_c    (s_fc),
      .flag_v    (s_fv),
      .flag_z    (s_fz),
      .flag_n    (s_fn)
    );

    initial begin
      done_flag = 1'b0;
      s_rst_n = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0;
      s_a = '0; s_b = '0; s_cin = 1'b0; s_op = 1'b0;
      repeat (3) @(posedge clk);
      #1 s_rst_n = 1'b1;
      for (int k = 0; k < 1000; k++) begin
        int   t;
        int   lat;
        res_t r;
        t = 0;
        @(posedge clk); #1;
        while (!s_in_ready && t < 20) begin
          @(posedge clk); #1;
          t++;
        end
        check($sformatf("sweep%0d_in_ready", g), s_in_ready, 1);
        s_a   = SW'($urandom);
        s_b   = SW'($urandom);
        s_cin = 1'($urandom_range(0, 1));
        s_op  = 1'($urandom_range(0, 1));
        r = model(SW, 32'(s_a), 32'(s_b), s_cin, s_op);
        s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        lat = 1;
        while (!s_out_valid && lat < SN + 10) begin
          @(posedge clk); #1;
          lat++;
        end
        check($sformatf("sweep%0d_latency", g), lat, SN + 1);
        check($sformatf("sweep%0d_result", g), {s_sum, s_fc, s_fv, s_fz, s_fn},
              {r.sum[SW-1:0], r.c, r.v, r.z, r.n});
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
      end
      done_flag = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int t;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; op = 1'b0;
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", dut_res, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("release_in_ready_low", in_ready, 0);
    @(posedge clk); #1;
    check("first_edge_in_ready", in_ready, 1);

    drive_op("add_wrap",   16'h0001, 16'hFFFF, 1'b0, 1'b0, 0, 1'b0, 1'b1, {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});
    drive_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 1'b1, {16'h8000, 1'b0, 1'b1, 1'b0, 1'b1});
    drive_op("add_cin",    16'h00FF, 16'h0000, 1'b1, 1'b0, 0, 1'b1, 1'b1, {16'h0100, 1'b0, 1'b0, 1'b0, 1'b0});
    drive_op("sub_neg",    16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0, 1'b1, {16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1});
    drive_op("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1'b0, 1'b1, {16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0});
    drive_op("sub_borrow", 16'h0010, 16'h0010, 1'b1, 1'b1, 0, 1'b0, 1'b1, {16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1});
    drive_op("sub_zero",   16'hABCD, 16'hABCD, 1'b0, 1'b1, 0, 1'b0, 1'b1, {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});
    drive_op("backpress",  16'h4321, 16'h1234, 1'b0, 1'b0, 3, 1'b0, 1'b1, {16'h5555, 1'b0, 1'b0, 1'b0, 1'b0});
    drive_op("after_bp",   16'h0F0F, 16'h00F1, 1'b0, 1'b0, 0, 1'b0, 1'b1, {16'h1000, 1'b0, 1'b0, 1'b0, 1'b0});

    // Reset during the second RUN cycle drops the operation.
    t = 0;
    @(posedge clk); #1;
    while (!in_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_result", dut_res, 0);
    check("midrun_rst_out_valid", out_valid, 0);
    check("midrun_rst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive_op("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 0, 1'b0, 1'b1, {16'h2345, 1'b0, 1'b0, 1'b0, 1'b0});

    for (int k = 0; k < 20; k++) begin
      drive_op("rand", 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0, 1'b0, '0);
    end

    t = 0;
    while (!(g_sweep[0].done_flag && g_sweep[1].done_flag && g_sweep[2].done_flag) && t < 60000) begin
      @(posedge clk);
      t++;
    end
    check("sweep_complete", 64'(g_sweep[0].done_flag && g_sweep[1].done_flag && g_sweep[2].done_flag), 64'(1));
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_addsub.md
Name: multicycle_addsub

Overview:
- Parametrised, sequential successor to the team's fixed 16-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, reusing one CHUNK-bit ripple slice, so area trades against latency.
- Adds carry-in, subtract mode, ALU flags and valid/ready handshakes on both sides.
- Sits in cpu/alu, feeding the ALU result mux.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of CHUNK, otherwise elaboration error.
- CHUNK, 4, bits processed per cycle; 1 <= CHUNK <= WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands/op valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (ADD) / borrow-in (SUB).
- op  input  1  op_e: 0=ADD, 1=SUB.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- flag_c  output  1  carry-out of MSB (SUB: 1 = no borrow).
- flag_v  output  1  signed overflow.
- flag_z  output  1  sum == 0.
- flag_n  output  1  sum[WIDTH-1].

Behaviour:
- Reset (async, rst_n=0): state=IDLE, chunk counter=0, sum=0, all flags=0, out_valid=0, in_ready=0 while rst_n low; in_ready=1 from first clock edge after release (IDLE).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch a, b_eff, carry, and clear the counter.
    - ADD: b_eff = b, carry = cin.
    - SUB: b_eff = ~b, carry = ~cin.
  - Go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle adds slice idx of a and b_eff plus the carry register, writes that slice of sum, updates the carry, and increments idx.
  - After slice NCHUNK-1 (NCHUNK = WIDTH/CHUNK), go to DONE.
  - Exactly NCHUNK RUN cycles.
- DONE:
  - out_valid=1; sum and flags stable and held.
  - On out_ready, go to IDLE; out_valid drops next cycle.
  - in_ready=0 in DONE: no same-cycle accept.
- Latency: out_valid asserts NCHUNK+1 edges after the accepting edge (NCHUNK=4 gives 5 edges). Throughput is 1 op per NCHUNK+2 cycles with out_ready held high.
- Flags (computed at the final slice, registered with sum):
  - flag_c = carry out of bit WIDTH-1.
  - flag_v = carry into MSB XOR carry out of MSB.
  - flag_z = (sum == 0).
  - flag_n = sum MSB.
- Outputs remain at the previous result while IDLE/RUN; only DONE qualifies them.
- in_valid is ignored outside IDLE; operands are captured, so input changes during RUN have no effect.
- out_ready outside DONE is ignored.
- Reset mid-RUN or mid-DONE: immediate return to reset values; the operation is dropped.
- CHUNK == WIDTH degenerates to one RUN cycle and must still follow the FSM.
- Counter width: $clog2(NCHUNK), minimum 1 bit.

Decomposition:
- Package alu_pkg holds:
  - op_e (ADD, SUB);
  - state_e (IDLE, RUN, DONE);
  - the ALU flag struct alu_flags_t {c, v, z, n}, used on the flag outputs.
- One sub-module, ripple_slice #(CHUNK): combinational CHUNK-bit ripple-carry adder built from the existing 1-bit adder cell; ports a, b, cin, sum, cout, plus c_msb_in for overflow.

Test Plan (WIDTH=16, CHUNK=4 unless noted):
- ADD 0x0001+0xFFFF, cin=0 -> sum=0x0000, c=1, z=1, v=0, n=0; out_valid exactly 5 edges after accept.
- ADD 0x7FFF+0x0001 -> sum=0x8000, v=1, n=1, c=0. ADD 0x00FF+0x0000 with cin=1 -> sum=0x0100 (carry crosses a slice boundary).
- SUB 0x0005-0x0007, cin=0 -> sum=0xFFFE, c=0, n=1, v=0. SUB 0x8000-0x0001 -> sum=0x7FFF, v=1, c=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> sum/flags/out_valid stable, in_ready=0, in_valid pulses ignored. Release -> IDLE, next op accepted.
- rst_n low during 2nd RUN cycle -> sum=0, flags=0, out_valid=0 immediately; after release a fresh ADD 0x1234+0x1111 -> 0x2345.
- Parameter sweep CHUNK=1, 16 (WIDTH=16) and WIDTH=32/CHUNK=8: 1000 random ADD/SUB ops vs reference model; latency = WIDTH/CHUNK+1.
